// File: rtl/fb_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module  : fb_pixel_writer
// Brief   : Clips engine pixels, converts to linear addresses, queues them and
//           writes them to the framebuffer; signals completion after the last write.
// Revision: 1.0  initial release
// ============================================================================
module fb_pixel_writer #(
    parameter int CORDW = 16,
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int COLRW = 4,
    parameter int ADDRW = 19,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    input  logic                    drawing,
    input  logic        [COLRW-1:0] colr,
    input  logic                    eng_done,
    output logic                    oe,
    output logic                    fb_we,
    output logic        [ADDRW-1:0] fb_addr,
    output logic        [COLRW-1:0] fb_colr,
    input  logic                    fb_ready,
    output logic                    busy,
    output logic                    done,
    output logic             [15:0] clip_cnt
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int OCCW = PTRW + 2;
    localparam int ENTW = ADDRW + COLRW;

    localparam logic signed [CORDW-1:0] C_H_RES = CORDW'(H_RES);
    localparam logic signed [CORDW-1:0] C_V_RES = CORDW'(V_RES);
    localparam logic        [OCCW-1:0]  C_OE_MAX = OCCW'(DEPTH - 2);

    // registered state
    logic [ENTW-1:0]  mem_q [DEPTH];
    logic [ENTW-1:0]  mem_d [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTRW:0]    count_q, count_d;
    logic             s1_valid_q, s1_valid_d;
    logic [ADDRW-1:0] s1_addr_q, s1_addr_d;
    logic [COLRW-1:0] s1_colr_q, s1_colr_d;
    logic             pending_q, pending_d;
    logic [15:0]      clip_cnt_q, clip_cnt_d;

    // combinational helpers
    logic [OCCW-1:0]  occ;
    logic             accept;
    logic             in_bounds;
    logic [31:0]      lin_addr;
    logic             push;
    logic             pop;

    always_comb begin
        occ       = OCCW'(count_q) + OCCW'(s1_valid_q);
        // oe depends only on registered occupancy, never on the engine inputs
        oe        = (occ <= C_OE_MAX);
        accept    = drawing && oe;
        in_bounds = !x[CORDW-1] && (x < C_H_RES) && !y[CORDW-1] && (y < C_V_RES);
        lin_addr  = 32'(32'(y) * 32'(H_RES) + 32'(x));

        fb_we              = (count_q != '0);
        {fb_colr, fb_addr} = mem_q[rd_ptr_q];
        push               = s1_valid_q;
        pop                = fb_we && fb_ready;

        busy = pending_q || (occ != '0);
        done = pending_q && (occ == '0) && !accept;
    end

    always_comb begin
        s1_valid_d = accept && in_bounds;
        s1_addr_d  = s1_addr_q;
        s1_colr_d  = s1_colr_q;
        if (accept && in_bounds) begin
            s1_addr_d = ADDRW'(lin_addr);
            s1_colr_d = colr;
        end

        clip_cnt_d = clip_cnt_q;
        if (accept && !in_bounds && (clip_cnt_q != 16'hFFFF)) begin
            clip_cnt_d = clip_cnt_q + 16'd1;
        end

        // a done pulse also swallows any eng_done arriving in the same cycle
        pending_d = done ? 1'b0 : (pending_q || eng_done);
    end

    // FIFO bookkeeping; the oe threshold guarantees a push always finds space
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {s1_colr_q, s1_addr_q};
            wr_ptr_d        = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTRW+1)'(1);
            2'b01:   count_d = count_q - (PTRW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_colr_q  <= '0;
            pending_q  <= 1'b0;
            clip_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s1_colr_q  <= s1_colr_d;
            pending_q  <= pending_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign clip_cnt = clip_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fb_pixel_writer
// Brief   : Directed self-checking bench for fb_pixel_writer.
// Revision: 1.0  initial release
// ============================================================================
module tb_fb_pixel_writer;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] x = '0;
    logic signed [15:0] y = '0;
    logic               drawing = 1'b0;
    logic        [3:0]  colr = '0;
    logic               eng_done = 1'b0;
    logic               oe;
    logic               fb_we;
    logic        [18:0] fb_addr;
    logic        [3:0]  fb_colr;
    logic               fb_ready = 1'b0;
    logic               busy;
    logic               done;
    logic        [15:0] clip_cnt;

    int checks = 0;
    int errors = 0;

    // every accepted framebuffer write, as {colr, addr}
    logic [22:0] wlog [$];

    fb_pixel_writer dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .y        (y),
        .drawing  (drawing),
        .colr     (colr),
        .eng_done (eng_done),
        .oe       (oe),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_colr  (fb_colr),
        .fb_ready (fb_ready),
        .busy     (busy),
        .done     (done),
        .clip_cnt (clip_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // drive one cycle's inputs on the falling edge, then sample 1 ns later
    task automatic step(input logic d, input int xi, input int yi, input int ci,
                        input logic rdy, input logic ed);
        @(negedge clk);
        drawing  = d;
        x        = 16'(xi);
        y        = 16'(yi);
        colr     = 4'(ci);
        fb_ready = rdy;
        eng_done = ed;
        #1;
        if (fb_we && fb_ready) wlog.push_back({fb_colr, fb_addr});
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 0, 0, 0, rdy, 1'b0);
    endtask

    initial begin
        int idx;
        int oe_low;
        int bad;
        int pulses;

        // reset
        repeat (3) @(negedge clk);
        #1;
        chk("rst_oe", 32'(oe), 32'd1);
        chk("rst_we", 32'(fb_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_clip", 32'(clip_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // single pixel latency and completion
        step(1'b1, 3, 2, 5, 1'b1, 1'b0);
        chk("single_oe", 32'(oe), 32'd1);
        chk("single_we_n", 32'(fb_we), 32'd0);
        idle(1'b1);
        chk("single_we_n1", 32'(fb_we), 32'd0);
        idle(1'b1);
        chk("single_we_n2", 32'(fb_we), 32'd1);
        chk("single_addr", 32'(fb_addr), 32'd1283);
        chk("single_colr", 32'(fb_colr), 32'd5);
        idle(1'b1);
        chk("single_we_n3", 32'(fb_we), 32'd0);
        chk("single_busy_idle", 32'(busy), 32'd0);
        step(1'b0, 0, 0, 0, 1'b1, 1'b1);
        chk("single_done_early", 32'(done), 32'd0);
        idle(1'b1);
        chk("single_done", 32'(done), 32'd1);
        chk("single_busy_pend", 32'(busy), 32'd1);
        idle(1'b1);
        chk("single_done_once", 32'(done), 32'd0);
        chk("single_busy_end", 32'(busy), 32'd0);

        // clipping corners
        wlog.delete();
        step(1'b1, -1, 0, 1, 1'b1, 1'b0);
        step(1'b1, 640, 0, 2, 1'b1, 1'b0);
        step(1'b1, 0, 480, 3, 1'b1, 1'b0);
        step(1'b1, 639, 479, 9, 1'b1, 1'b0);
        repeat (4) idle(1'b1);
        chk("clip_writes", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) begin
            chk("clip_corner_addr", 32'(wlog[0][18:0]), 32'd307199);
            chk("clip_corner_colr", 32'(wlog[0][22:19]), 32'd9);
        end
        chk("clip_cnt3", 32'(clip_cnt), 32'd3);
        step(1'b1, 0, -1, 0, 1'b1, 1'b0);
        repeat (2) idle(1'b1);
        chk("clip_cnt4", 32'(clip_cnt), 32'd4);
        chk("clip_writes2", 32'(wlog.size()), 32'd1);

        // backpressure: engine holds a pixel until oe takes it
        wlog.delete();
        idx = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, idx, 10, idx, 1'b0, 1'b0);
            chk($sformatf("bp_oe_%0d", k), 32'(oe), (k <= 6) ? 32'd1 : 32'd0);
            if (oe) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd7);
        chk("bp_we_held", 32'(fb_we), 32'd1);
        for (int j = 0; j < 9; j++) begin
            step(1'b0, 0, 0, 0, 1'b1, 1'b0);
            if (j == 0) chk("bp_oe_full", 32'(oe), 32'd0);
            if (j == 1) chk("bp_oe_reassert", 32'(oe), 32'd1);
            if (j == 6) chk("bp_we_last", 32'(fb_we), 32'd1);
            if (j == 7) chk("bp_we_empty", 32'(fb_we), 32'd0);
        end
        chk("bp_writes", 32'(wlog.size()), 32'd7);
        bad = 0;
        foreach (wlog[i]) if (wlog[i] !== {4'(i), 19'(6400 + i)}) bad++;
        chk("bp_order", 32'(bad), 32'd0);

        // streaming 100 pixels at full rate
        wlog.delete();
        oe_low = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, i, 30, i, 1'b1, 1'b0);
            if (!oe) oe_low++;
            if (i >= 2) chk($sformatf("stream_we_%0d", i), 32'(fb_we), 32'd1);
        end
        repeat (3) idle(1'b1);
        chk("stream_oe_low", 32'(oe_low), 32'd0);
        chk("stream_writes", 32'(wlog.size()), 32'd100);
        bad = 0;
        foreach (wlog[i]) if (wlog[i] !== {4'(i), 19'(19200 + i)}) bad++;
        chk("stream_order", 32'(bad), 32'd0);

        // fb_ready toggling every cycle
        wlog.delete();
        idx = 0;
        for (int k = 0; k < 300 && idx < 40; k++) begin
            step(1'b1, idx + 100, 40, idx, k[0] == 1'b0, 1'b0);
            if (oe) idx++;
        end
        chk("toggle_accepted", 32'(idx), 32'd40);
        for (int k = 0; k < 100 && (fb_we || busy); k++) begin
            step(1'b0, 0, 0, 0, k[0] == 1'b0, 1'b0);
        end
        chk("toggle_drained", 32'(busy), 32'd0);
        chk("toggle_writes", 32'(wlog.size()), 32'd40);
        bad = 0;
        foreach (wlog[i]) if (wlog[i] !== {4'(i), 19'(25700 + i)}) bad++;
        chk("toggle_order", 32'(bad), 32'd0);

        // asynchronous reset with pixels queued
        for (int i = 0; i < 5; i++) step(1'b1, i, 1, i, 1'b0, 1'b0);
        repeat (2) idle(1'b0);
        chk("ar_we_before", 32'(fb_we), 32'd1);
        chk("ar_clip_before", 32'(clip_cnt), 32'd4);
        #1 rst = 1'b0;
        #1;
        chk("ar_we", 32'(fb_we), 32'd0);
        chk("ar_oe", 32'(oe), 32'd1);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_clip", 32'(clip_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wlog.delete();
        repeat (4) idle(1'b1);
        chk("ar_no_stale", 32'(wlog.size()), 32'd0);
        chk("ar_we_after", 32'(fb_we), 32'd0);

        // eng_done while pixels are stuck in the queue
        wlog.delete();
        step(1'b1, 5, 5, 1, 1'b0, 1'b0);
        step(1'b1, 6, 5, 2, 1'b0, 1'b0);
        step(1'b1, 7, 5, 3, 1'b0, 1'b0);
        repeat (2) idle(1'b0);
        step(1'b0, 0, 0, 0, 1'b0, 1'b1);
        chk("ed_done_hold0", 32'(done), 32'd0);
        idle(1'b0);
        chk("ed_done_hold1", 32'(done), 32'd0);
        chk("ed_busy_hold", 32'(busy), 32'd1);
        for (int j = 0; j < 3; j++) begin
            idle(1'b1);
            chk($sformatf("ed_done_w%0d", j), 32'(done), 32'd0);
            chk($sformatf("ed_busy_w%0d", j), 32'(busy), 32'd1);
        end
        idle(1'b1);
        chk("ed_done_pulse", 32'(done), 32'd1);
        chk("ed_busy_pulse", 32'(busy), 32'd1);
        pulses = 0;
        for (int j = 0; j < 4; j++) begin
            idle(1'b1);
            if (done) pulses++;
        end
        chk("ed_single_pulse", 32'(pulses), 32'd0);
        chk("ed_busy_end", 32'(busy), 32'd0);
        chk("ed_writes", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) chk("ed_last_addr", 32'(wlog[2][18:0]), 32'd3207);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Receiving end of the drawing-engine pixel interface. It consumes the `x`/`y`/`drawing` stream produced by the line and polygon drawers and drives their `oe` input as backpressure.
- Clips each pixel to the screen, converts in-bounds pixels to a linear framebuffer address, and buffers them in a small FIFO.
- Writes buffered pixels to framebuffer memory through a valid/ready port.
- Reports completion once the engine's `done` has been seen and every queued pixel has been written.

Parameters:
- CORDW, 16, signed coordinate width; matches the drawing engines.
- H_RES, 640, horizontal resolution in pixels.
- V_RES, 480, vertical resolution in pixels.
- COLRW, 4, colour width.
- ADDRW, 19, framebuffer address width; must satisfy 2^ADDRW >= H_RES*V_RES.
- DEPTH, 8, FIFO depth; power of two, >= 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- x  in  CORDW  signed pixel x from the drawing engine.
- y  in  CORDW  signed pixel y from the drawing engine.
- drawing  in  1  pixel valid from the drawing engine.
- colr  in  COLRW  pixel colour, sampled together with x/y.
- eng_done  in  1  one-cycle done pulse from the drawing engine.
- oe  out  1  output enable to the engine; pixels are only presented while high.
- fb_we  out  1  framebuffer write valid.
- fb_addr  out  ADDRW  framebuffer write address.
- fb_colr  out  COLRW  framebuffer write data.
- fb_ready  in  1  framebuffer accepts the write this cycle.
- busy  out  1  pixels pending or completion outstanding.
- done  out  1  all pixels written; high for exactly one cycle.
- clip_cnt  out  16  count of pixels dropped by clipping; saturates at 16'hFFFF.

Behaviour:
- Reset (rst low, asynchronous): FIFO emptied, stage register cleared, pending-done cleared, clip_cnt=0.
  - Output values during reset: oe=1, fb_we=0, busy=0, done=0.
  - fb_addr/fb_colr are don't-care while fb_we=0.
- Occupancy (occ) = FIFO count + s1_valid.
- oe = (occ <= DEPTH-2). It is combinational from registered state only, with no path from any input.
- Accept: a pixel is accepted on any cycle where drawing && oe. If drawing is high while oe is low, the pixel is ignored; the engine holds it by design.
- Clip: an accepted pixel is out-of-bounds if x<0, x>=H_RES, y<0 or y>=V_RES, using signed compares.
  - Out-of-bounds pixels are dropped and clip_cnt increments by 1 (saturating).
  - Boundary: (H_RES-1, V_RES-1) is in-bounds.
- Stage 1 (registered): for an in-bounds pixel, s1_valid<=1, s1_addr<=y*H_RES+x truncated to ADDRW, s1_colr<=colr. Otherwise s1_valid<=0.
- Stage 2: s1_valid pushes into the FIFO on the next edge unconditionally. The oe rule guarantees space, so no overflow is possible.
- FIFO is show-ahead:
  - fb_we = !empty, with fb_addr/fb_colr = head entry.
  - The head is popped on the edge where fb_we && fb_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Read/write pointers wrap modulo DEPTH.
- Latency: a pixel accepted in cycle N appears on fb_we in cycle N+2 when the FIFO was empty. Sustained throughput is 1 pixel/cycle while fb_ready=1.
- Ordering: writes occur strictly in acceptance order.
- Completion:
  - eng_done sets pending.
  - While pending, done pulses high for exactly one cycle on the first cycle where occ==0 and no accept occurs in that cycle; pending clears on that same cycle.
  - If eng_done arrives while occ==0, done is asserted in the following cycle.
  - If eng_done and the last pop coincide, done follows in the next cycle.
  - A second eng_done while pending is absorbed, so only one done pulse results.
- busy = pending || occ!=0.
- fb_ready is ignored while fb_we=0.

Test Plan:
- Single pixel (3,2) colr=5 accepted in cycle N, fb_ready=1 -> fb_we high only in cycle N+2 with fb_addr=1283, fb_colr=5. Then eng_done -> done pulses one cycle, busy returns to 0.
- Clip corners: pixels (-1,0), (640,0), (0,480), (639,479) -> exactly one write, fb_addr=307199; clip_cnt=3; (0,-1) -> clip_cnt=4.
- Backpressure with fb_ready=0 and drawing held high: oe drops after 7 accepted pixels (DEPTH=8), and 7 entries are queued. Then fb_ready=1 -> 7 writes on consecutive cycles in order, and oe re-asserts as occupancy falls to 6.
- Streaming 100 in-bounds pixels with fb_ready=1 -> oe never deasserts and 100 writes occur at 1/cycle. Toggling fb_ready 1-0 every cycle -> no loss or duplication, and addresses match in order.
- Reset mid-operation: 5 pixels queued, rst driven low -> fb_we=0 immediately without waiting for a clock edge, oe=1, busy=0, clip_cnt=0. After release, no stale writes.
- eng_done while 3 pixels are queued and fb_ready=0 -> done stays 0. After release, done pulses exactly once, in the cycle after the third write; busy stays high until that pulse.
